// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder/subtractor that feeds one nibble per cycle through a 4-bit
// ripple-carry slice, keeping the inter-nibble carry in a flop.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;

    // 4-bit ripple-carry slice on the low nibble of the shift registers
    logic [4:0] slice_c;
    logic [3:0] slice_s;

    assign slice_c[0] = carry_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign slice_s[gi]   = a_sh_q[gi] ^ b_sh_q[gi] ^ slice_c[gi];
        assign slice_c[gi+1] = (a_sh_q[gi] & b_sh_q[gi]) |
                               (slice_c[gi] & (a_sh_q[gi] ^ b_sh_q[gi]));
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {slice_s, res_q[WIDTH-1:4]};
                carry_d = slice_c[4];
                a_sh_d  = {4'b0000, a_sh_q[WIDTH-1:4]};
                b_sh_d  = {4'b0000, b_sh_q[WIDTH-1:4]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(NSLICE - 1)) begin
                    sum_d   = {slice_s, res_q[WIDTH-1:4]};
                    cout_d  = slice_c[4];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    // in_ready gated by reset so nothing is accepted while reset is held
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
